hazard_ctrl: RTL

- Parametrised pipeline hazard and stall controller for the in-order core. Next generation of the single-cycle load-use/divide stall logic.
- Generates per-pipeline-register stall and flush vectors. Covers:
  - multi-bubble load-use with configurable load latency;
  - I-side and D-side miss stalls;
  - exception flush, including flushes that arrive during a freeze and must wait.
- Sits beside the datapath. Drives every pipeline register's stall/flush pins.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/hazard_ctrl_lu_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: hazard controller state, debug view and
// pipeline register indices used for the stall/flush vectors.
package cpu_pkg;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } hazard_state_e;

  // Pipeline register positions inside the stall/flush vectors.
  localparam int REG_PC    = 0;
  localparam int REG_IFID  = 1;
  localparam int REG_IDEX  = 2;
  localparam int REG_EXMEM = 3;

  // Observable internals of the hazard controller.
  typedef struct packed {
    hazard_state_e state;
    logic [2:0]    cnt;
    logic          flush_pend;
  } hazard_dbg_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard detector: flags a load in EX whose destination is a
// register the ID instruction reads. Register 0 never creates a hazard.
// Purely combinational so the forwarding unit can reuse it as-is.
module lu_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_rmem_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_reg1_read_i,
  input  logic              id_reg2_read_i,
  output logic              lu_hit_o
);

  logic rs_match;
  logic rt_match;

  // Compare the EX destination against each ID source actually read.
  always_comb begin
    rs_match = (ex_wd_i == id_rs_i) & id_reg1_read_i;
    rt_match = (ex_wd_i == id_rt_i) & id_reg2_read_i;
    lu_hit_o = ex_rmem_i & ex_wreg_i & (ex_wd_i != '0) & (rs_match | rt_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller. Produces per-register stall
// (hold) and flush (load bubble) vectors combinationally from the
// current stall sources and a small load-use FSM.
//
// Handshake: there is no valid/ready pair here; every input is a level
// sampled each cycle, and stall_o/flush_o are valid in the same cycle.
// A freeze (ex_busy_i | mem_busy_i) holds all internal state, and an
// exception flush seen during a freeze is latched in flush_pend and
// applied on the first unfrozen cycle.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int NREG     = 5,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_busy_i,
  input  logic              ex_busy_i,
  input  logic              mem_busy_i,
  input  logic              exc_flush_i,
  input  logic              ex_rmem_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_reg1_read_i,
  input  logic              id_reg2_read_i,
  output logic [NREG-1:0]   stall_o,
  output logic [NREG-1:0]   flush_o,
  output logic              flush_pend_o,
  output logic [31:0]       stall_cnt_o,
  output hazard_dbg_t       dbg_o
);

  // Remaining bubbles loaded when a multi-bubble load-use is entered.
  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  hazard_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [31:0]   stall_cnt_q;

  logic lu_hit;
  logic freeze;
  logic fl;
  logic lu;

  lu_detect #(
    .REG_AW(REG_AW)
  ) u_lu_detect (
    .ex_rmem_i      (ex_rmem_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg2_read_i (id_reg2_read_i),
    .lu_hit_o       (lu_hit)
  );

  // Hazard conditions shared by the output and next-state logic.
  always_comb begin
    freeze = ex_busy_i | mem_busy_i;
    fl     = exc_flush_i | flush_pend_q;
    lu     = (state_q == LU) | ((state_q == RUN) & lu_hit);
  end

  // State register: FSM, bubble counter and pending flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic; a freeze blocks every transition.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    if (freeze) begin
      if (exc_flush_i) flush_pend_d = 1'b1;
    end else if (fl) begin
      state_d      = RUN;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (state_q == LU) begin
      if (cnt_q == 3'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (lu_hit) begin
      if (LOAD_LAT > 1) begin
        state_d = LU;
        cnt_d   = LU_INIT;
      end
    end
  end

  // Output logic: strict priority reset > freeze > flush > load-use > fetch miss.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (!resetn) begin
      flush_o = '1;
    end else if (freeze) begin
      stall_o = '1;
    end else if (fl) begin
      flush_o[REG_IFID]  = 1'b1;
      flush_o[REG_IDEX]  = 1'b1;
      flush_o[REG_EXMEM] = 1'b1;
    end else if (lu) begin
      stall_o[REG_PC]   = 1'b1;
      stall_o[REG_IFID] = 1'b1;
      flush_o[REG_IDEX] = 1'b1;
    end else if (if_busy_i) begin
      stall_o[REG_PC]   = 1'b1;
      flush_o[REG_IFID] = 1'b1;
    end
  end

  // Free-running count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (stall_o[REG_PC]) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush_pend_o     = resetn & flush_pend_q;
  assign stall_cnt_o      = stall_cnt_q;
  assign dbg_o.state      = state_q;
  assign dbg_o.cnt        = cnt_q;
  assign dbg_o.flush_pend = flush_pend_q;

endmodule
